// File: rtl/jtpinpon_gfx_arb_if.sv
// ROM request/response bus. The master (requester) drives cs/addr and
// receives data/ok; the slave (server) answers. W is the address width.
interface jtpinpon_gfx_arb_if #(
    parameter int W = 12
);
    logic         cs;
    logic [W-1:0] addr;
    logic [15:0]  data;
    logic         ok;

    modport master (output cs, addr, input data, ok);
    modport slave  (input cs, addr, output data, ok);
endinterface

// File: rtl/jtpinpon_gfx_arb.sv
// Graphics ROM slot arbiter: shares one SDRAM port between the character
// fetcher and the object fetcher. Each requester has a one-word cache
// (tag/data/valid). Priority follows blanking, with a starve flag so that a
// loser is served next. A stuck SDRAM request is re-issued after TOUT cycles.
// Optional statistics counters are enabled by defining
// JTPINPON_GFXARB_STATS_EN; otherwise st_dout reads as zero.
module jtpinpon_gfx_arb #(
    parameter int AW   = 13,
    parameter int RW   = 12,
    parameter int TOUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               LHBL,
    jtpinpon_gfx_arb_if.slave  char_bus,
    jtpinpon_gfx_arb_if.slave  obj_bus,
    jtpinpon_gfx_arb_if.master rom_bus,
    output logic               tout_err,
    input  logic [7:0]         debug_bus,
    output logic [7:0]         st_dout
);
    localparam int CW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RETRY} state_t;
    typedef enum logic [1:0] {STV_NONE, STV_CHAR, STV_OBJ} starve_t;

    state_t        state, state_nx;
    starve_t       starve, starve_nx;

    logic [CW-1:0] tcnt, tcnt_nx;
    logic [RW-1:0] char_tag, obj_tag;
    logic          char_vld, obj_vld;
    logic [15:0]   char_data, obj_data;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;

    logic          char_ok, obj_ok;
    logic          char_pend, obj_pend;
    logic          grant_char, grant_obj;
    logic          capture, timeout, rearm, tick;

    // Cache hit: combinational so ok drops the same cycle the address moves.
    assign char_ok   = char_bus.cs & char_vld & (char_bus.addr == char_tag);
    assign obj_ok    = obj_bus.cs  & obj_vld  & (obj_bus.addr  == obj_tag);
    assign char_pend = char_bus.cs & ~char_ok;
    assign obj_pend  = obj_bus.cs  & ~obj_ok;
    assign tcnt_nx   = tcnt + 1'b1;

    assign char_bus.ok   = char_ok;
    assign char_bus.data = char_data;
    assign obj_bus.ok    = obj_ok;
    assign obj_bus.data  = obj_data;
    assign rom_bus.cs    = rom_cs;
    assign rom_bus.addr  = rom_addr;

    // State and starve flag registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state  <= IDLE;
            starve <= STV_NONE;
        end else begin
            state  <= state_nx;
            starve <= starve_nx;
        end
    end

    // Next state, arbitration decision and datapath strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_nx   = state;
        starve_nx  = starve;
        grant_char = 1'b0;
        grant_obj  = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        rearm      = 1'b0;
        tick       = 1'b0;
        case (state)
            IDLE: begin
                if (char_pend && obj_pend) begin
                    // Starved requester wins; otherwise blanking decides.
                    if (starve == STV_CHAR)      grant_char = 1'b1;
                    else if (starve == STV_OBJ)  grant_obj  = 1'b1;
                    else if (LHBL)               grant_char = 1'b1;
                    else                         grant_obj  = 1'b1;
                    starve_nx = grant_char ? STV_OBJ : STV_CHAR;
                end else if (char_pend) begin
                    grant_char = 1'b1;
                    if (starve == STV_CHAR) starve_nx = STV_NONE;
                end else if (obj_pend) begin
                    grant_obj = 1'b1;
                    if (starve == STV_OBJ) starve_nx = STV_NONE;
                end
                if (grant_char || grant_obj) state_nx = WAIT;
            end
            WAIT: begin
                // rom_ok in the first WAIT cycle belongs to the old address.
                if (rom_bus.ok && tcnt != '0) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end else if (tcnt_nx == CW'(TOUT)) begin
                    timeout  = 1'b1;
                    state_nx = RETRY;
                end else begin
                    tick = 1'b1;
                end
            end
            RETRY: begin
                rearm    = 1'b1;
                state_nx = WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request port, caches, timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            char_data <= '0;
            obj_data  <= '0;
            char_vld  <= 1'b0;
            obj_vld   <= 1'b0;
            char_tag  <= '0;
            obj_tag   <= '0;
            tout_err  <= 1'b0;
            tcnt      <= '0;
        end else begin
            if (grant_char) begin
                char_tag <= char_bus.addr;
                char_vld <= 1'b0;
                rom_addr <= {1'b0, char_bus.addr};
                rom_cs   <= 1'b1;
                tcnt     <= '0;
            end
            if (grant_obj) begin
                obj_tag  <= obj_bus.addr;
                obj_vld  <= 1'b0;
                rom_addr <= {1'b1, obj_bus.addr};
                rom_cs   <= 1'b1;
                tcnt     <= '0;
            end
            if (capture) begin
                // Fill under the latched tag even if the requester moved on.
                if (rom_addr[AW-1]) begin
                    obj_data <= rom_bus.data;
                    obj_vld  <= 1'b1;
                end else begin
                    char_data <= rom_bus.data;
                    char_vld  <= 1'b1;
                end
                rom_cs <= 1'b0;
                tcnt   <= '0;
            end
            if (timeout) begin
                rom_cs   <= 1'b0;
                tout_err <= 1'b1;
                tcnt     <= '0;
            end
            if (rearm) rom_cs <= 1'b1;
            if (tick)  tcnt   <= tcnt_nx;
        end
    end

`ifdef JTPINPON_GFXARB_STATS_EN
    logic [7:0] stall_cnt, tout_cnt;
    logic       lhbl_l;
    logic       char_owner;

    // Char owns the slot when granted now or when the transfer in flight is its.
    assign char_owner = grant_char | ((state != IDLE) & ~rom_addr[AW-1]);

    // Saturating stall and timeout counters; stalls clear each line.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            tout_cnt  <= '0;
            lhbl_l    <= 1'b0;
        end else begin
            lhbl_l <= LHBL;
            if (lhbl_l && !LHBL)
                stall_cnt <= '0;
            else if (char_pend && !char_owner && stall_cnt != 8'hFF)
                stall_cnt <= stall_cnt + 8'd1;
            if (timeout && tout_cnt != 8'hFF)
                tout_cnt <= tout_cnt + 8'd1;
        end
    end

    assign st_dout = debug_bus[0] ? tout_cnt : stall_cnt;
`else
    assign st_dout = 8'd0;
`endif

    logic unused_debug;
    assign unused_debug = ^debug_bus;

endmodule

// File: tb/tb_jtpinpon_gfx_arb.sv
// Bench for jtpinpon_gfx_arb: table-driven handshake vectors, directed
// corner sequences (held rom_ok, contention fairness, timeout, reset in
// WAIT) and a randomized run against a transaction-level reference model.
module tb_jtpinpon_gfx_arb;
    localparam int AW = 13, RW = 12, TOUT = 63;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lhbl = 1'b1;
    logic [7:0] debug_bus = 8'd0;
    logic [7:0] st_dout;
    logic       tout_err;

    jtpinpon_gfx_arb_if #(.W(RW)) char_bus ();
    jtpinpon_gfx_arb_if #(.W(RW)) obj_bus ();
    jtpinpon_gfx_arb_if #(.W(AW)) rom_bus ();

    jtpinpon_gfx_arb #(.AW(AW), .RW(RW), .TOUT(TOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .LHBL      (lhbl),
        .char_bus  (char_bus),
        .obj_bus   (obj_bus),
        .rom_bus   (rom_bus),
        .tout_err  (tout_err),
        .debug_bus (debug_bus),
        .st_dout   (st_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        c_cs;
        logic [11:0] c_addr;
        logic        o_cs;
        logic [11:0] o_addr;
        logic        lh;
        logic        r_ok;
        logic [15:0] r_data;
        logic        e_cs;
        logic [12:0] e_addr;
        logic        e_cok;
        logic [15:0] e_cdata;
        logic        e_ook;
        logic [15:0] e_odata;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(logic c_cs, logic [11:0] c_addr, logic o_cs, logic [11:0] o_addr,
                                logic lh, logic r_ok, logic [15:0] r_data,
                                logic e_cs, logic [12:0] e_addr, logic e_cok, logic [15:0] e_cdata,
                                logic e_ook, logic [15:0] e_odata);
        vec_t v;
        v = {c_cs, c_addr, o_cs, o_addr, lh, r_ok, r_data, e_cs, e_addr, e_cok, e_cdata, e_ook, e_odata};
        return v;
    endfunction

    // Reference model state: per-requester cache plus slot bookkeeping.
    bit          m_vld[2];
    logic [11:0] m_tag[2];
    logic [15:0] m_dat[2];
    int          m_busy, m_who, m_age, m_starve;
    bit          m_retry, m_cs, m_err;
    logic [12:0] m_addr;

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_vld[r] = 1'b0;
            m_tag[r] = '0;
            m_dat[r] = '0;
        end
        m_busy = 0; m_who = 0; m_age = 0; m_starve = -1;
        m_retry = 1'b0; m_cs = 1'b0; m_err = 1'b0; m_addr = '0;
    endtask

    initial begin
        int cnt, w, who, deaf;
        logic [11:0] ca, oa;
        logic [15:0] exp_st;

        char_bus.cs = 1'b0; char_bus.addr = '0;
        obj_bus.cs  = 1'b0; obj_bus.addr  = '0;
        rom_bus.ok  = 1'b0; rom_bus.data  = '0;

        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_rom_cs",    rom_bus.cs,    1'b0);
        check("rst_rom_addr",  rom_bus.addr,  13'h0);
        check("rst_tout_err",  tout_err,      1'b0);
        check("rst_char_data", char_bus.data, 16'h0);
        check("rst_obj_data",  obj_bus.data,  16'h0);
        check("rst_st_dout",   st_dout,       8'h0);

        // Basic fetch, contention with LHBL=1 then LHBL=0
        vt[0]  = mk(1,12'h123,0,12'h000,1,0,16'h0000, 0,13'h0000,0,16'h0,0,16'h0);
        vt[1]  = mk(1,12'h123,0,12'h000,1,0,16'h0000, 1,13'h0123,0,16'h0,0,16'h0);
        vt[2]  = mk(1,12'h123,0,12'h000,1,1,16'hA5A5, 1,13'h0123,0,16'h0,0,16'h0);
        vt[3]  = mk(1,12'h123,0,12'h000,1,0,16'h0000, 0,13'h0000,1,16'hA5A5,0,16'h0);
        vt[4]  = mk(1,12'h123,0,12'h000,1,0,16'h0000, 0,13'h0000,1,16'hA5A5,0,16'h0);
        vt[5]  = mk(1,12'h010,1,12'h020,1,0,16'h0000, 0,13'h0000,0,16'h0,0,16'h0);
        vt[6]  = mk(1,12'h010,1,12'h020,1,0,16'h0000, 1,13'h0010,0,16'h0,0,16'h0);
        vt[7]  = mk(1,12'h010,1,12'h020,1,1,16'h1111, 1,13'h0010,0,16'h0,0,16'h0);
        vt[8]  = mk(1,12'h010,1,12'h020,1,0,16'h0000, 0,13'h0000,1,16'h1111,0,16'h0);
        vt[9]  = mk(1,12'h010,1,12'h020,1,0,16'h0000, 1,13'h1020,1,16'h1111,0,16'h0);
        vt[10] = mk(1,12'h010,1,12'h020,1,1,16'h2222, 1,13'h1020,1,16'h1111,0,16'h0);
        vt[11] = mk(1,12'h010,1,12'h020,1,0,16'h0000, 0,13'h0000,1,16'h1111,1,16'h2222);
        vt[12] = mk(1,12'h030,1,12'h040,0,0,16'h0000, 0,13'h0000,0,16'h0,0,16'h0);
        vt[13] = mk(1,12'h030,1,12'h040,0,0,16'h0000, 1,13'h1040,0,16'h0,0,16'h0);
        vt[14] = mk(1,12'h030,1,12'h040,0,1,16'h3333, 1,13'h1040,0,16'h0,0,16'h0);
        vt[15] = mk(1,12'h030,1,12'h040,0,0,16'h0000, 0,13'h0000,0,16'h0,1,16'h3333);
        vt[16] = mk(1,12'h030,1,12'h040,0,0,16'h0000, 1,13'h0030,0,16'h0,1,16'h3333);
        vt[17] = mk(1,12'h030,1,12'h040,0,1,16'h4444, 1,13'h0030,0,16'h0,1,16'h3333);
        vt[18] = mk(1,12'h030,1,12'h040,0,0,16'h0000, 0,13'h0000,1,16'h4444,1,16'h3333);
        vt[19] = mk(0,12'h030,0,12'h040,1,0,16'h0000, 0,13'h0000,0,16'h0,0,16'h0);

        for (int i = 0; i < 20; i++) begin
            char_bus.cs = vt[i].c_cs; char_bus.addr = vt[i].c_addr;
            obj_bus.cs  = vt[i].o_cs; obj_bus.addr  = vt[i].o_addr;
            lhbl = vt[i].lh; rom_bus.ok = vt[i].r_ok; rom_bus.data = vt[i].r_data;
            #1;
            check($sformatf("vec%0d_rom_cs", i), rom_bus.cs, vt[i].e_cs);
            if (vt[i].e_cs) check($sformatf("vec%0d_rom_addr", i), rom_bus.addr, vt[i].e_addr);
            check($sformatf("vec%0d_char_ok", i), char_bus.ok, vt[i].e_cok);
            if (vt[i].e_cok) check($sformatf("vec%0d_char_data", i), char_bus.data, vt[i].e_cdata);
            check($sformatf("vec%0d_obj_ok", i), obj_bus.ok, vt[i].e_ook);
            if (vt[i].e_ook) check($sformatf("vec%0d_obj_data", i), obj_bus.data, vt[i].e_odata);
            tick();
        end

        // rom_ok held high: ignored in the first WAIT cycle
        char_bus.cs = 1'b1; char_bus.addr = 12'h055;
        rom_bus.ok = 1'b1; rom_bus.data = 16'h5555;
        #1;
        check("held_pre_ok", char_bus.ok, 1'b0);
        tick();
        check("held_grant_cs",   rom_bus.cs,   1'b1);
        check("held_grant_addr", rom_bus.addr, 13'h0055);
        tick();
        check("held_first_wait_cs", rom_bus.cs,  1'b1);
        check("held_first_wait_ok", char_bus.ok, 1'b0);
        tick();
        check("held_capture_ok",   char_bus.ok,   1'b1);
        check("held_capture_data", char_bus.data, 16'h5555);
        check("held_capture_cs",   rom_bus.cs,    1'b0);
        rom_bus.ok = 1'b0; char_bus.cs = 1'b0;
        tick();

        // Sustained contention: grants must alternate char/obj
        lhbl = 1'b1; ca = 12'h200; oa = 12'h300;
        char_bus.cs = 1'b1; char_bus.addr = ca;
        obj_bus.cs  = 1'b1; obj_bus.addr  = oa;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (!rom_bus.cs && w < 10) begin
                tick();
                w++;
            end
            check($sformatf("alt%0d_granted", g), rom_bus.cs, 1'b1);
            who = int'(rom_bus.addr[12]);
            check($sformatf("alt%0d_who", g), who, g % 2);
            tick();
            rom_bus.ok = 1'b1;
            tick();
            rom_bus.ok = 1'b0;
            if (who == 0) begin ca = ca + 12'd1; char_bus.addr = ca; end
            else          begin oa = oa + 12'd1; obj_bus.addr  = oa; end
            if (g == 5) begin char_bus.cs = 1'b0; obj_bus.cs = 1'b0; end
        end
        tick();

        // rom_ok never comes: timeout and retry with the same address
        char_bus.cs = 1'b1; char_bus.addr = 12'h077; rom_bus.data = 16'h7777;
        tick();
        check("to_grant_cs",  rom_bus.cs, 1'b1);
        check("to_err_before", tout_err,  1'b0);
        cnt = 1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (rom_bus.cs) cnt++;
            else break;
        end
        check("to_wait_cycles", cnt, TOUT);
        check("to_drop_cs",     rom_bus.cs, 1'b0);
        check("to_err_set",     tout_err,   1'b1);
        tick();
        check("to_retry_cs",   rom_bus.cs,   1'b1);
        check("to_retry_addr", rom_bus.addr, 13'h0077);
        debug_bus = 8'h01;
        #1;
`ifdef JTPINPON_GFXARB_STATS_EN
        exp_st = 16'd1;
`else
        exp_st = 16'd0;
`endif
        check("to_st_dout", st_dout, exp_st[7:0]);
        rom_bus.ok = 1'b1;
        tick();
        tick();
        rom_bus.ok = 1'b0;
        check("to_fill_ok",   char_bus.ok,   1'b1);
        check("to_fill_data", char_bus.data, 16'h7777);

        // Reset while in WAIT drops the request; a late rom_ok is ignored
        char_bus.addr = 12'h099;
        tick();
        tick();
        check("rw_grant_cs", rom_bus.cs, 1'b1);
        rst = 1'b1; char_bus.cs = 1'b0;
        tick();
        rst = 1'b0;
        check("rw_cs_dropped", rom_bus.cs, 1'b0);
        check("rw_err_clear",  tout_err,   1'b0);
        char_bus.cs = 1'b1; char_bus.addr = 12'h077;
        #1;
        check("rw_cache_cleared", char_bus.ok, 1'b0);
        char_bus.cs = 1'b0;
        rom_bus.ok = 1'b1;
        tick();
        rom_bus.ok = 1'b0;
        tick();
        check("rw_late_ok_cs", rom_bus.cs, 1'b0);
        char_bus.cs = 1'b1; char_bus.addr = 12'h099;
        #1;
        check("rw_late_ok_no_fill", char_bus.ok, 1'b0);
        check("rw_st_dout", st_dout, 8'h00);
        char_bus.cs = 1'b0;
        debug_bus = 8'h00;

        // Randomized run against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        deaf = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          cs_r[2];
            logic [11:0] ad_r[2];
            bit          ok_r[2];
            bit          pend[2];
            int          win;

            char_bus.cs = ($urandom_range(0, 9) < 7);
            obj_bus.cs  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) char_bus.addr = 12'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) obj_bus.addr  = 12'($urandom_range(0, 3) + 8);
            if ($urandom_range(0, 19) == 0) lhbl = ~lhbl;
            if ($urandom_range(0, 399) == 0) deaf = 80;
            rom_bus.ok   = (deaf == 0) && ($urandom_range(0, 2) == 0);
            rom_bus.data = 16'($urandom);
            if (deaf > 0) deaf--;
            #1;

            cs_r[0] = char_bus.cs; ad_r[0] = char_bus.addr;
            cs_r[1] = obj_bus.cs;  ad_r[1] = obj_bus.addr;
            for (int r = 0; r < 2; r++) begin
                ok_r[r] = cs_r[r] && m_vld[r] && (ad_r[r] == m_tag[r]);
                pend[r] = cs_r[r] && !ok_r[r];
            end

            check("rnd_char_ok", char_bus.ok, ok_r[0]);
            if (ok_r[0]) check("rnd_char_data", char_bus.data, m_dat[0]);
            check("rnd_obj_ok", obj_bus.ok, ok_r[1]);
            if (ok_r[1]) check("rnd_obj_data", obj_bus.data, m_dat[1]);
            check("rnd_rom_cs", rom_bus.cs, m_cs);
            if (m_cs) check("rnd_rom_addr", rom_bus.addr, m_addr);
            check("rnd_tout_err", tout_err, m_err);

            // Advance the model by one clock using the inputs just applied.
            if (m_busy == 0) begin
                win = -1;
                if (pend[0] && pend[1]) begin
                    win = (m_starve >= 0) ? m_starve : (lhbl ? 0 : 1);
                    m_starve = 1 - win;
                end else if (pend[0] || pend[1]) begin
                    win = pend[0] ? 0 : 1;
                    if (m_starve == win) m_starve = -1;
                end
                if (win >= 0) begin
                    m_vld[win] = 1'b0;
                    m_tag[win] = ad_r[win];
                    m_addr = {win[0], ad_r[win]};
                    m_cs = 1'b1; m_busy = 1; m_who = win; m_age = 0;
                end
            end else if (m_retry) begin
                m_retry = 1'b0;
                m_cs = 1'b1;
            end else if (rom_bus.ok && m_age > 0) begin
                m_vld[m_who] = 1'b1;
                m_dat[m_who] = rom_bus.data;
                m_cs = 1'b0; m_busy = 0;
            end else if (m_age + 1 == TOUT) begin
                m_retry = 1'b1; m_cs = 1'b0; m_err = 1'b1; m_age = 0;
            end else begin
                m_age++;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
